// File: rtl/spe_sum_scheduler.sv
// spe_sum_scheduler: buffers five PPE partial-sum lanes and sequences the Sum PE potential update through OMEM
module spe_sum_scheduler #(
  parameter int SUM_WIDTH  = 13,
  parameter int NUM_LANES  = 5,
  parameter int FIFO_DEPTH = 6,
  parameter int OUT_COUNT  = 441,
  parameter int ADDR_W     = 9,
  parameter int THRESHOLD  = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           ps_valid,
  output logic [NUM_LANES-1:0]           ps_ready,
  input  logic [NUM_LANES*SUM_WIDTH-1:0] ps_data,
  input  logic                           first_ts_done,
  output logic                           rd_req_valid,
  input  logic                           rd_req_ready,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic                           rd_resp_valid,
  input  logic [SUM_WIDTH-1:0]           rd_resp_data,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [SUM_WIDTH-1:0]           wr_potential,
  output logic                           wr_spike,
  output logic                           timestep_done,
  output logic                           busy
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SW3 = SUM_WIDTH + 3;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, UPDATE, WRITE} state_t;
  state_t state, state_n;
  logic [SUM_WIDTH-1:0] mem [NUM_LANES][FIFO_DEPTH];
  logic [PW-1:0] wp [NUM_LANES];
  logic [PW-1:0] rp [NUM_LANES];
  logic [CW-1:0] cnt [NUM_LANES];
  logic [NUM_LANES-1:0] push, nonempty;
  logic pop, last, over;
  logic [SW3-1:0] sum_c, sum_reg;
  logic [SUM_WIDTH-1:0] prev, newp, pot_reg;
  logic spike_reg, later_ts, ts_done;
  logic [ADDR_W-1:0] out_idx;
  // ready comes from the registered count only, so a full lane cannot be refilled in its pop cycle
  always_comb begin
    sum_c = '0;
    ps_ready = '0;
    nonempty = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      ps_ready[i] = !reset && cnt[i] < CW'(FIFO_DEPTH);
      nonempty[i] = cnt[i] != '0;
      sum_c = sum_c + SW3'(mem[i][rp[i]]);
    end
  end
  assign push = ps_valid & ps_ready;
  assign pop  = state == IDLE && &nonempty;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NUM_LANES; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
    else
      for (int i = 0; i < NUM_LANES; i++) begin
        if (push[i]) wp[i] <= wp[i] == PW'(FIFO_DEPTH - 1) ? '0 : wp[i] + 1'b1;
        if (pop) rp[i] <= rp[i] == PW'(FIFO_DEPTH - 1) ? '0 : rp[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop);
      end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_LANES; i++)
      if (push[i]) mem[i][wp[i]] <= ps_data[i*SUM_WIDTH +: SUM_WIDTH];
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pop) state_n = later_ts ? REQ : UPDATE;
      REQ:     if (rd_req_ready) state_n = WAIT;
      WAIT:    if (rd_resp_valid) state_n = UPDATE;
      UPDATE:  state_n = WRITE;
      WRITE:   if (wr_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign newp = SUM_WIDTH'({3'b000, prev} + sum_reg);
  assign over = newp > SUM_WIDTH'(THRESHOLD);
  assign last = out_idx == ADDR_W'(OUT_COUNT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sum_reg   <= '0;
      prev      <= '0;
      pot_reg   <= '0;
      spike_reg <= 1'b0;
      out_idx   <= '0;
      later_ts  <= 1'b0;
      ts_done   <= 1'b0;
    end else begin
      ts_done <= 1'b0;
      if (first_ts_done) later_ts <= 1'b1;
      if (pop) sum_reg <= sum_c;
      if (pop && !later_ts) prev <= '0;
      if (state == WAIT && rd_resp_valid) prev <= rd_resp_data;
      if (state == UPDATE) begin
        spike_reg <= over;
        pot_reg   <= over ? newp - SUM_WIDTH'(THRESHOLD) : newp;
      end
      if (state == WRITE && wr_ready) begin
        out_idx <= last ? '0 : out_idx + 1'b1;
        ts_done <= last;
      end
    end
  assign rd_req_valid  = state == REQ;
  assign rd_addr       = rd_req_valid ? out_idx : '0;
  assign wr_valid      = state == WRITE;
  assign wr_addr       = wr_valid ? out_idx : '0;
  assign wr_potential  = wr_valid ? pot_reg : '0;
  assign wr_spike      = wr_valid & spike_reg;
  assign timestep_done = ts_done;
  assign busy          = state != IDLE;
endmodule

// File: tb/tb_spe_sum_scheduler.sv
// tb_spe_sum_scheduler: directed vectors with hand-computed potentials, spikes, addresses and latencies
module tb_spe_sum_scheduler;
  localparam int SW = 13;
  logic clk = 0, reset = 1;
  logic [4:0] ps_valid = '0, ps_ready;
  logic [5*SW-1:0] ps_data = '0;
  logic first_ts_done = 0, rd_req_valid, rd_req_ready = 0, rd_resp_valid = 0;
  logic [8:0] rd_addr, wr_addr;
  logic [SW-1:0] rd_resp_data = '0, wr_potential;
  logic wr_valid, wr_ready = 1, wr_spike, timestep_done, busy;
  int checks = 0, errors = 0, ts_pulses = 0;

  spe_sum_scheduler dut (
    .clk(clk), .reset(reset), .ps_valid(ps_valid), .ps_ready(ps_ready), .ps_data(ps_data),
    .first_ts_done(first_ts_done), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr(rd_addr), .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_potential(wr_potential),
    .wr_spike(wr_spike), .timestep_done(timestep_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (timestep_done) ts_pulses++;
  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5*SW-1:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {SW'(e), SW'(d), SW'(c), SW'(b), SW'(a)};
  endfunction

  task automatic run_pixel(input logic [4:0] mask, input logic [5*SW-1:0] d, input logic later,
                           input int resp, input int ea, input int ep, input logic es, input logic stall);
    int n;
    logic saw;
    n = 0;
    saw = 0;
    ps_valid = mask;
    ps_data = d;
    tick();
    ps_valid = '0;
    if (later) begin
      while (!rd_req_valid && n < 20) begin tick(); n++; end
      check("rd_req", 32'(rd_req_valid), 1);
      check("rd_addr", 32'(rd_addr), 32'(ea));
      rd_req_ready = 1;
      tick();
      rd_req_ready = 0;
      tick();
      tick();
      rd_resp_data = SW'(resp);
      rd_resp_valid = 1;
      tick();
      rd_resp_valid = 0;
      n = 0;
    end
    wr_ready = !stall;
    while (!wr_valid && n < 20) begin saw |= rd_req_valid; tick(); n++; end
    if (!later) check("no_rd", 32'(saw), 0);
    check("latency", 32'(n), later ? 1 : 2);
    check("wr_addr", 32'(wr_addr), 32'(ea));
    check("wr_pot", 32'(wr_potential), 32'(ep));
    check("wr_spike", 32'(wr_spike), 32'(es));
    if (stall) begin
      tick();
      check("stall_valid", 32'(wr_valid), 1);
      check("stall_pot", 32'(wr_potential), 32'(ep));
      wr_ready = 1;
    end
    tick();
  endtask

  initial begin
    #1;
    check("rst_ready", 32'(ps_ready), 0);
    check("rst_outs", 32'({rd_req_valid, wr_valid, wr_spike, timestep_done, busy}), 0);
    tick();
    tick();
    reset = 0;
    tick();
    check("init_ready", 32'(ps_ready), 32'h1f);
    check("init_busy", 32'(busy), 0);
    // timestep 1: no OMEM read, strict threshold
    run_pixel(5'h1f, pk(10, 20, 5, 15, 12), 0, 0, 0, 62, 0, 0);
    run_pixel(5'h1f, pk(20, 20, 20, 20, 20), 0, 0, 1, 36, 1, 0);
    // lane 0 fills while other lanes idle
    ps_valid = 5'b00001;
    for (int k = 0; k < 6; k++) begin
      ps_data = pk(100 + k, 0, 0, 0, 0);
      tick();
    end
    check("lane0_full", 32'(ps_ready[0]), 0);
    check("others_ready", 32'(ps_ready[4:1]), 32'hf);
    ps_data = pk(106, 1, 1, 1, 1);
    tick();
    check("lane0_held", 32'(ps_ready[0]), 0);
    check("no_pop", 32'(busy), 0);
    ps_valid = 5'h1f;
    tick();
    check("full_on_pop", 32'(ps_ready[0]), 0);
    ps_valid = 5'b00001;
    tick();
    check("ready_back", 32'(ps_ready[0]), 1);
    check("busy_upd", 32'(busy), 1);
    tick();
    ps_valid = '0;
    check("l_valid", 32'(wr_valid), 1);
    check("l_addr", 32'(wr_addr), 2);
    check("l_pot", 32'(wr_potential), 40);
    check("l_spike", 32'(wr_spike), 1);
    tick();
    for (int k = 1; k <= 6; k++)
      run_pixel(5'b11110, pk(0, 0, 0, 0, 0), 0, 0, 2 + k, 36 + k, 1, 0);
    // run the rest of the timestep to the wrap
    for (int p = 9; p < 441; p++)
      run_pixel(5'h1f, pk(0, 0, 0, 0, 0), 0, 0, p, 0, 0, 0);
    check("ts_done", 32'(timestep_done), 1);
    tick();
    check("ts_done_off", 32'(timestep_done), 0);
    check("ts_pulses", 32'(ts_pulses), 1);
    // later timesteps read the previous potential
    first_ts_done = 1;
    tick();
    first_ts_done = 0;
    run_pixel(5'h1f, pk(10, 10, 10, 10, 10), 1, 30, 0, 16, 1, 1);
    run_pixel(5'h1f, pk(10, 10, 10, 10, 10), 1, 14, 1, 64, 0, 0);
    // reset while waiting on OMEM with a backlog of three
    ps_data = pk(20, 20, 20, 20, 20);
    ps_valid = 5'h1f;
    rd_req_ready = 1;
    for (int k = 0; k < 4; k++) tick();
    ps_valid = '0;
    rd_req_ready = 0;
    check("wait_busy", 32'(busy), 1);
    check("wait_noreq", 32'(rd_req_valid), 0);
    reset = 1;
    #1;
    check("mid_rst_ready", 32'(ps_ready), 0);
    check("mid_rst_outs", 32'({rd_req_valid, wr_valid, wr_spike, timestep_done, busy}), 0);
    check("mid_rst_addr", 32'({rd_addr, wr_addr, wr_potential}), 0);
    tick();
    tick();
    reset = 0;
    tick();
    check("post_ready", 32'(ps_ready), 32'h1f);
    rd_resp_data = SW'(500);
    rd_resp_valid = 1;
    tick();
    rd_resp_valid = 0;
    for (int k = 0; k < 3; k++) tick();
    check("late_resp_busy", 32'(busy), 0);
    check("late_resp_wr", 32'(wr_valid), 0);
    run_pixel(5'h1f, pk(10, 20, 5, 15, 12), 0, 0, 0, 62, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
